// File: rtl/fault_pkg.sv
// Shared types for the fault supervisor: state encoding and fault-code constants.
package fault_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_QUAL    = 3'd2,
    ST_FAULT   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  localparam logic [1:0] FC_NONE = 2'b00;
  localparam logic [1:0] FC_OV   = 2'b01;
  localparam logic [1:0] FC_UV   = 2'b10;
  localparam logic [1:0] FC_BOTH = 2'b11;

  // Map the raw comparator flags onto a fault code.
  function automatic logic [1:0] flags_to_code(input logic ov, input logic uv);
    logic [1:0] code;
    unique case ({uv, ov})
      2'b01:   code = FC_OV;
      2'b10:   code = FC_UV;
      2'b11:   code = FC_BOTH;
      default: code = FC_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/fault_supervisor_fsm_if.sv
// Flag / host / power-stage signal bundle for fault_supervisor_fsm.
interface fault_supervisor_fsm_if #(
  parameter int unsigned RET_W = 4
);
  logic             ov_flag;
  logic             uv_flag;
  logic             enable_req;
  logic             clear_fault;
  logic             pwr_en;
  logic             fault;
  logic [1:0]       fault_code;
  logic             lockout;
  logic [RET_W-1:0] retry_cnt;
  logic [2:0]       state;

  modport master (
    output ov_flag, uv_flag, enable_req, clear_fault,
    input  pwr_en, fault, fault_code, lockout, retry_cnt, state
  );

  modport slave (
    input  ov_flag, uv_flag, enable_req, clear_fault,
    output pwr_en, fault, fault_code, lockout, retry_cnt, state
  );
endinterface

// File: rtl/fault_timer.sv
// Saturating up-counter with clear/enable; o_hit_c flags a chosen count value.
module fault_timer #(
  parameter int unsigned W        = 16,
  parameter int unsigned TERMINAL = 8,
  parameter int unsigned HIT      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit_c
);

  localparam logic [W-1:0] TERM_V = W'(TERMINAL);
  localparam logic [W-1:0] HIT_V  = W'(HIT);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != TERM_V)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_hit_c = (r_cnt == HIT_V);

endmodule

// File: rtl/fault_supervisor_fsm.sv
// Power-stage fault supervisor: qualifies OV/UV flags, forces the stage off, cools down, restarts.
// Optional FAULT_SUPERVISOR_AUTORETRY_EN enables automatic restarts with retry limit and LOCKOUT.
module fault_supervisor_fsm
  import fault_pkg::*;
#(
  parameter int unsigned DEB_CYCLES      = 8,
  parameter int unsigned COOLDOWN_CYCLES = 1000,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned CNT_W           = 16,
  parameter int unsigned RET_W           = 4
) (
  input logic                 clk,
  input logic                 rst,
  fault_supervisor_fsm_if.slave bus
);

  // Reject parameter sets whose counters cannot hold their terminal counts.
  if ((DEB_CYCLES == 0) || (COOLDOWN_CYCLES == 0) ||
      (64'(DEB_CYCLES) >= (64'd1 << CNT_W)) ||
      (64'(COOLDOWN_CYCLES) >= (64'd1 << CNT_W)) ||
      (64'(MAX_RETRIES) >= (64'd1 << RET_W))) begin : g_bad_params
    $error("fault_supervisor_fsm: illegal parameter combination");
  end

  state_e     r_state;
  state_e     w_state_nxt;
  logic [1:0] r_seed;
  logic [1:0] w_seed_nxt;
  logic [1:0] w_flag_code;
  logic       w_flag_any;
  logic       w_deb_hit;
  logic       w_cool_done;
  logic       w_exit_ok;
  logic       w_deb_clr;
  logic       w_cool_clr;
  logic       r_pwr_en;
  logic       r_fault;
  logic [1:0] r_fault_code;

`ifdef FAULT_SUPERVISOR_AUTORETRY_EN
  logic [RET_W-1:0] r_retry;
  logic [RET_W-1:0] w_retry_nxt;
  logic             r_lockout;
`endif

  assign w_flag_any  = bus.ov_flag | bus.uv_flag;
  assign w_flag_code = flags_to_code(bus.ov_flag, bus.uv_flag);
  assign w_exit_ok   = w_cool_done & ~w_flag_any;

  // Debounce count is only meaningful while qualifying; cooldown restarts at each FAULT entry.
  assign w_deb_clr  = (w_state_nxt != ST_QUAL);
  assign w_cool_clr = ~((r_state == ST_FAULT) && (w_state_nxt == ST_FAULT));

  fault_timer #(
    .W        (CNT_W),
    .TERMINAL (DEB_CYCLES),
    .HIT      (DEB_CYCLES - 1)
  ) u_deb_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_deb_clr),
    .i_en    (w_flag_any),
    .o_hit_c (w_deb_hit)
  );

  fault_timer #(
    .W        (CNT_W),
    .TERMINAL (COOLDOWN_CYCLES),
    .HIT      (COOLDOWN_CYCLES)
  ) u_cool_timer (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_cool_clr),
    .i_en    (1'b1),
    .o_hit_c (w_cool_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_seed  <= FC_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_seed  <= w_seed_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_seed_nxt  = r_seed;
`ifdef FAULT_SUPERVISOR_AUTORETRY_EN
    w_retry_nxt = r_retry;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (bus.enable_req && !w_flag_any) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (!bus.enable_req) begin
          w_state_nxt = ST_IDLE;
        end else if (w_flag_any) begin
          w_seed_nxt  = w_flag_code;
          w_state_nxt = (DEB_CYCLES == 1) ? ST_FAULT : ST_QUAL;
        end
      end
      ST_QUAL: begin
        if (!bus.enable_req) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_flag_any) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_seed_nxt = r_seed | w_flag_code;
          if (w_deb_hit) w_state_nxt = ST_FAULT;
        end
      end
      ST_FAULT: begin
`ifdef FAULT_SUPERVISOR_AUTORETRY_EN
        // A host clear outranks a simultaneous automatic restart.
        if (bus.clear_fault) begin
          w_state_nxt = ST_IDLE;
          w_retry_nxt = '0;
        end else if (w_exit_ok) begin
          if (r_retry == RET_W'(MAX_RETRIES)) begin
            w_state_nxt = ST_LOCKOUT;
          end else begin
            w_retry_nxt = r_retry + RET_W'(1);
            w_state_nxt = bus.enable_req ? ST_RUN : ST_IDLE;
          end
        end
`else
        if (bus.clear_fault && w_exit_ok) w_state_nxt = ST_IDLE;
`endif
      end
      ST_LOCKOUT: begin
        if (bus.clear_fault && !w_flag_any) begin
          w_state_nxt = ST_IDLE;
`ifdef FAULT_SUPERVISOR_AUTORETRY_EN
          w_retry_nxt = '0;
`endif
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_RUN)) w_seed_nxt = FC_NONE;
  end

  // Outputs are registered from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwr_en     <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= FC_NONE;
    end else begin
      r_pwr_en     <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_QUAL);
      r_fault      <= (w_state_nxt == ST_FAULT) || (w_state_nxt == ST_LOCKOUT);
      r_fault_code <= ((w_state_nxt == ST_FAULT) || (w_state_nxt == ST_LOCKOUT)) ?
                      w_seed_nxt : FC_NONE;
    end
  end

`ifdef FAULT_SUPERVISOR_AUTORETRY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retry   <= '0;
      r_lockout <= 1'b0;
    end else begin
      r_retry   <= w_retry_nxt;
      r_lockout <= (w_state_nxt == ST_LOCKOUT);
    end
  end

  assign bus.retry_cnt = r_retry;
  assign bus.lockout   = r_lockout;
`else
  assign bus.retry_cnt = '0;
  assign bus.lockout   = 1'b0;
`endif

  assign bus.pwr_en     = r_pwr_en;
  assign bus.fault      = r_fault;
  assign bus.fault_code = r_fault_code;
  assign bus.state      = 3'(r_state);

endmodule

// File: tb/tb_fault_supervisor_fsm.sv
// Directed testbench for fault_supervisor_fsm (DEB=8, COOLDOWN=16, MAX_RETRIES=3).
module tb_fault_supervisor_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fault_supervisor_fsm_if #(.RET_W(4)) bus ();

  fault_supervisor_fsm #(
    .DEB_CYCLES      (8),
    .COOLDOWN_CYCLES (16),
    .MAX_RETRIES     (3),
    .CNT_W           (16),
    .RET_W           (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ov_flag = 1'b0; bus.uv_flag = 1'b0;
    bus.enable_req = 1'b0; bus.clear_fault = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", bus.state); end
    checks++; if (bus.pwr_en !== 1'b0) begin errors++; $display("FAIL reset_pwr_en got %b want 0", bus.pwr_en); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", bus.fault); end
    checks++; if (bus.fault_code !== 2'b00) begin errors++; $display("FAIL reset_code got %b want 00", bus.fault_code); end
    checks++; if (bus.lockout !== 1'b0) begin errors++; $display("FAIL reset_lockout got %b want 0", bus.lockout); end
    checks++; if (bus.retry_cnt !== 4'd0) begin errors++; $display("FAIL reset_retry got %0d want 0", bus.retry_cnt); end
  endtask

  task automatic test_start();
    do_reset();
    bus.enable_req = 1'b1; bus.ov_flag = 1'b1;
    tick(2);
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL idle_block_state got %0d want 0", bus.state); end
    checks++; if (bus.fault !== 1'b0) begin errors++; $display("FAIL idle_block_fault got %b want 0", bus.fault); end
    bus.ov_flag = 1'b0;
    tick(1);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL start_state got %0d want 1", bus.state); end
    checks++; if (bus.pwr_en !== 1'b1) begin errors++; $display("FAIL start_pwr_en got %b want 1", bus.pwr_en); end
    checks++; if ({bus.fault, bus.fault_code, bus.lockout} !== 4'b0000) begin errors++; $display("FAIL start_others got %b want 0000", {bus.fault, bus.fault_code, bus.lockout}); end
    bus.clear_fault = 1'b1; tick(1); bus.clear_fault = 1'b0;
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL run_clear_state got %0d want 1", bus.state); end
    bus.enable_req = 1'b0;
    tick(1);
    checks++; if ({bus.state, bus.pwr_en} !== 4'b0000) begin errors++; $display("FAIL disable_state_pwr got %b want 0000", {bus.state, bus.pwr_en}); end
  endtask

  task automatic test_short_flag();
    do_reset();
    bus.enable_req = 1'b1; tick(1);
    bus.ov_flag = 1'b1; tick(7);
    checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL short_state got %0d want 2", bus.state); end
    checks++; if ({bus.pwr_en, bus.fault, bus.fault_code} !== 4'b1000) begin errors++; $display("FAIL short_outputs got %b want 1000", {bus.pwr_en, bus.fault, bus.fault_code}); end
    bus.ov_flag = 1'b0; tick(1);
    checks++; if ({bus.state, bus.pwr_en} !== 4'b0011) begin errors++; $display("FAIL short_release got %b want 0011", {bus.state, bus.pwr_en}); end
  endtask

  task automatic test_gap();
    bus.ov_flag = 1'b1; tick(5);
    bus.ov_flag = 1'b0; tick(1);
    checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL gap_state got %0d want 1", bus.state); end
    bus.ov_flag = 1'b1; tick(7);
    checks++; if ({bus.state, bus.fault} !== 4'b0100) begin errors++; $display("FAIL gap_requal got %b want 0100", {bus.state, bus.fault}); end
    bus.ov_flag = 1'b0; tick(1);
  endtask

  task automatic test_fault_both();
    bus.ov_flag = 1'b1; tick(3);
    bus.uv_flag = 1'b1; tick(4);
    checks++; if ({bus.state, bus.pwr_en} !== 4'b0101) begin errors++; $display("FAIL both_pre got %b want 0101", {bus.state, bus.pwr_en}); end
    tick(1);
    checks++; if (bus.state !== 3'd3) begin errors++; $display("FAIL both_state got %0d want 3", bus.state); end
    checks++; if ({bus.fault, bus.pwr_en, bus.lockout} !== 3'b100) begin errors++; $display("FAIL both_outputs got %b want 100", {bus.fault, bus.pwr_en, bus.lockout}); end
    checks++; if (bus.fault_code !== 2'b11) begin errors++; $display("FAIL both_code got %b want 11", bus.fault_code); end
  endtask

`ifdef FAULT_SUPERVISOR_AUTORETRY_EN
  task automatic test_autoretry();
    do_reset();
    bus.enable_req = 1'b1; tick(1);
    for (int r = 0; r < 4; r++) begin
      bus.ov_flag = 1'b1; tick(8);
      checks++; if ({bus.state, bus.retry_cnt} !== {3'd3, 4'(r)}) begin errors++; $display("FAIL retry%0d_fault got %b want %b", r, {bus.state, bus.retry_cnt}, {3'd3, 4'(r)}); end
      bus.ov_flag = 1'b0; tick(16);
      checks++; if ({bus.state, bus.pwr_en} !== 4'b0110) begin errors++; $display("FAIL retry%0d_cool got %b want 0110", r, {bus.state, bus.pwr_en}); end
      tick(1);
      if (r < 3) begin
        checks++; if ({bus.state, bus.pwr_en, bus.retry_cnt} !== {3'd1, 1'b1, 4'(r + 1)}) begin errors++; $display("FAIL retry%0d_restart got %b want %b", r, {bus.state, bus.pwr_en, bus.retry_cnt}, {3'd1, 1'b1, 4'(r + 1)}); end
      end
    end
    checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL lockout_state got %0d want 4", bus.state); end
    checks++; if ({bus.lockout, bus.fault, bus.pwr_en, bus.fault_code, bus.retry_cnt} !== 9'b1_1_0_01_0011) begin errors++; $display("FAIL lockout_outputs got %b want 110010011", {bus.lockout, bus.fault, bus.pwr_en, bus.fault_code, bus.retry_cnt}); end
    bus.enable_req = 1'b0; tick(2); bus.enable_req = 1'b1;
    bus.ov_flag = 1'b1; bus.clear_fault = 1'b1; tick(1); bus.clear_fault = 1'b0;
    checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL lockout_hold got %0d want 4", bus.state); end
    bus.ov_flag = 1'b0; bus.clear_fault = 1'b1; tick(1); bus.clear_fault = 1'b0;
    checks++; if ({bus.state, bus.retry_cnt, bus.lockout, bus.fault_code} !== 10'b000_0000_0_00) begin errors++; $display("FAIL lockout_clear got %b want 0000000000", {bus.state, bus.retry_cnt, bus.lockout, bus.fault_code}); end
  endtask

  task automatic test_clear_wins();
    do_reset();
    bus.enable_req = 1'b1; tick(1);
    bus.ov_flag = 1'b1; tick(8); bus.ov_flag = 1'b0;
    bus.clear_fault = 1'b1; tick(1); bus.clear_fault = 1'b0;
    checks++; if (bus.state !== 3'd0) begin errors++; $display("FAIL early_clear got %0d want 0", bus.state); end
    tick(1);
    bus.ov_flag = 1'b1; tick(8); bus.ov_flag = 1'b0; tick(17);
    checks++; if ({bus.state, bus.retry_cnt} !== 7'b001_0001) begin errors++; $display("FAIL one_retry got %b want 0010001", {bus.state, bus.retry_cnt}); end
    bus.ov_flag = 1'b1; tick(8); bus.ov_flag = 1'b0; tick(16);
    bus.clear_fault = 1'b1; tick(1); bus.clear_fault = 1'b0;
    checks++; if ({bus.state, bus.retry_cnt} !== 7'b000_0000) begin errors++; $display("FAIL clear_wins got %b want 0000000", {bus.state, bus.retry_cnt}); end
  endtask
`else
  task automatic test_manual_clear();
    tick(5);
    bus.ov_flag = 1'b0; bus.uv_flag = 1'b0;
    tick(5);
    bus.clear_fault = 1'b1; tick(1); bus.clear_fault = 1'b0;
    checks++; if ({bus.state, bus.fault, bus.pwr_en} !== 5'b01110) begin errors++; $display("FAIL early_clear got %b want 01110", {bus.state, bus.fault, bus.pwr_en}); end
    tick(9);
    checks++; if ({bus.state, bus.fault_code} !== 5'b01111) begin errors++; $display("FAIL wait_clear got %b want 01111", {bus.state, bus.fault_code}); end
    bus.clear_fault = 1'b1; tick(1); bus.clear_fault = 1'b0;
    checks++; if ({bus.state, bus.fault, bus.fault_code, bus.pwr_en} !== 7'b0000000) begin errors++; $display("FAIL late_clear got %b want 0000000", {bus.state, bus.fault, bus.fault_code, bus.pwr_en}); end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    bus.enable_req = 1'b1; tick(1);
    bus.ov_flag = 1'b1; tick(3);
    checks++; if ({bus.state, bus.pwr_en} !== 4'b0101) begin errors++; $display("FAIL mid_pre got %b want 0101", {bus.state, bus.pwr_en}); end
    rst = 1'b1; tick(1); rst = 1'b0; bus.ov_flag = 1'b0;
    checks++; if ({bus.state, bus.pwr_en, bus.fault, bus.fault_code} !== 7'b0000000) begin errors++; $display("FAIL mid_rst got %b want 0000000", {bus.state, bus.pwr_en, bus.fault, bus.fault_code}); end
    tick(1);
    bus.ov_flag = 1'b1; tick(7);
    checks++; if ({bus.state, bus.fault} !== 4'b0100) begin errors++; $display("FAIL mid_requal got %b want 0100", {bus.state, bus.fault}); end
  endtask

  initial begin
    bus.ov_flag = 1'b0; bus.uv_flag = 1'b0;
    bus.enable_req = 1'b0; bus.clear_fault = 1'b0;
    test_reset();
    test_start();
    test_short_flag();
    test_gap();
    test_fault_both();
`ifdef FAULT_SUPERVISOR_AUTORETRY_EN
    test_autoretry();
    test_clear_wins();
`else
    test_manual_clear();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fault_supervisor_fsm.md
# fault_supervisor_fsm

Supervisory state machine that consumes the debounced over-/under-voltage flags produced by the ADC threshold comparator and sequences the power-stage enable. It qualifies flags over a programmable number of cycles, forces the stage off on a confirmed fault, enforces a cooldown, and either retries automatically or waits for a host clear. It sits between the ADC flag stage and the power-stage gate driver enable.

## Interface
- `DEB_CYCLES`, 8: consecutive cycles a flag must be high before a fault is declared; legal range ≥1.
- `COOLDOWN_CYCLES`, 1000: minimum cycles spent in FAULT with the stage off; legal range ≥1.
- `MAX_RETRIES`, 3: automatic restarts allowed before LOCKOUT; used only with auto-retry.
- `CNT_W`, 16: counter width; must satisfy 2^CNT_W > max(DEB_CYCLES, COOLDOWN_CYCLES).
- `RET_W`, 4: retry counter width; must satisfy 2^RET_W > MAX_RETRIES.

- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ov_flag`  in  1  over-voltage flag.
- `uv_flag`  in  1  under-voltage flag.
- `enable_req`  in  1  level; host requests the stage on.
- `clear_fault`  in  1  single-cycle pulse; host acknowledge of fault/lockout.
- `pwr_en`  out  1  power-stage enable.
- `fault`  out  1  high in FAULT and LOCKOUT.
- `fault_code`  out  2  bit0 = OV seen, bit1 = UV seen during qualification.
- `lockout`  out  1  high in LOCKOUT.
- `retry_cnt`  out  RET_W  automatic restarts since the last clear.
- `state`  out  3  current state encoding, for debug.

## Operation
- States: IDLE, RUN, QUAL, FAULT, LOCKOUT.
- `flag_any` = `ov_flag | uv_flag`. All outputs are registered.
- `pwr_en` = 1 in RUN and QUAL only.

**Transitions**
- **IDLE**
  - `enable_req & !flag_any` → RUN.
  - Otherwise stay in IDLE.
- **RUN**
  - `!enable_req` → IDLE. This has priority over every other condition.
  - `flag_any`: if `DEB_CYCLES == 1`, → FAULT; else → QUAL with deb_cnt = 1 and fault_code seeded with the flags.
- **QUAL**
  - `!enable_req` → IDLE.
  - `!flag_any` → RUN, with deb_cnt and the seed cleared.
  - Otherwise deb_cnt increments and fault_code ORs in the current flags.
  - When deb_cnt reaches DEB_CYCLES → FAULT.
- **FAULT**
  - Cooldown counter loads 0 on entry and increments, saturating at COOLDOWN_CYCLES.
  - Exit is eligible only when the cooldown is done and `!flag_any`. With flags still high, the block stays in FAULT with the counter saturated.
  - Exit rules are defined under Configuration.
- **LOCKOUT**
  - `clear_fault & !flag_any` → IDLE.
  - Otherwise stay in LOCKOUT, including across `enable_req` changes.

**Register rules**
- fault_code holds its value from fault declaration until IDLE is entered, where it is cleared. It reads 0 in RUN and QUAL.
- retry_cnt clears on `rst` and on an accepted `clear_fault`. It saturates at MAX_RETRIES.
- `clear_fault` in IDLE, RUN or QUAL is ignored.
- Flags in IDLE block the start; they never raise `fault`.

## Timing
- Reset values: state = IDLE, `pwr_en` = 0, `fault` = 0, `fault_code` = 0, `lockout` = 0, `retry_cnt` = 0, all counters = 0.
- Start latency: `enable_req` sampled high at edge N gives `pwr_en` = 1 after edge N.
- Fault latency: a flag sampled high at edges N … N+DEB_CYCLES−1 gives `pwr_en` = 0 and `fault` = 1 after edge N+DEB_CYCLES−1.
- A single-cycle flag gap restarts qualification.
- The stage stays off for at least COOLDOWN_CYCLES cycles.
- `rst` mid-operation returns the block to IDLE on the next edge and drops `pwr_en` immediately at that edge.
- Simultaneous `clear_fault` and a cooldown-done retry in FAULT: the clear wins. Next state is IDLE and retry_cnt = 0.

## Configuration
- Macro: `FAULT_SUPERVISOR_AUTORETRY_EN`.
- **Defined:**
  - On FAULT exit eligibility, if retry_cnt == MAX_RETRIES → LOCKOUT.
  - Else retry_cnt increments and the block goes → RUN if `enable_req`, else → IDLE.
  - `clear_fault` in FAULT forces → IDLE, regardless of cooldown, and resets retry_cnt.
- **Undefined:**
  - FAULT exits only on `clear_fault` with exit eligibility met, and goes → IDLE.
  - LOCKOUT is unreachable.
  - `retry_cnt` and `lockout` are tied to 0.

## Structure
- Shared package `fault_pkg`:
  - State encoding: IDLE = 0, RUN = 1, QUAL = 2, FAULT = 3, LOCKOUT = 4.
  - Fault code constants: FC_NONE = 2'b00, FC_OV = 2'b01, FC_UV = 2'b10, FC_BOTH = 2'b11.
- One sub-module, `fault_timer`, is natural: a saturating up-counter with clear, enable and done-at-terminal. It is instantiated twice, once for debounce and once for cooldown.

## Test plan
- Reset, then `enable_req` = 1 with flags low → `pwr_en` = 1 one cycle later, state = RUN, all other outputs 0.
- With DEB_CYCLES = 8, `ov_flag` high for 7 cycles then low → remains RUN/QUAL, `pwr_en` stays 1, `fault_code` = 0.
- `ov_flag` high for 3 cycles, then both flags high for 5 more cycles → FAULT after the 8th high edge, `fault_code` = 2'b11, `pwr_en` = 0.
- With auto-retry, MAX_RETRIES = 3 and COOLDOWN_CYCLES = 16, flag held high after each restart long enough to re-declare the fault → three restarts, then LOCKOUT with `lockout` = 1 and `retry_cnt` = 3. `clear_fault` with flags low → IDLE, `retry_cnt` = 0.
- Without the macro, flags clear 5 cycles into cooldown and `clear_fault` is pulsed at cycle 10 → ignored, state stays FAULT. `clear_fault` at cycle 20 → IDLE with `fault_code` = 0.
- `rst` asserted while in QUAL with `pwr_en` = 1 → IDLE and `pwr_en` = 0 after that edge, all counters 0.
